// File: rtl/bram_line_writer_pkg.sv
// Shared widths and FSM encodings for the port-A line fill engine.
// The lane buffer packs DATA_W-bit words into one LINE_W-bit memory line.
package bram_line_writer_pkg;

  localparam int DATA_W     = 16;
  localparam int LANES      = 8;
  localparam int ADDR_W     = 10;
  localparam int LINE_W     = DATA_W * LANES;
  localparam int LANE_IDX_W = $clog2(LANES);

  typedef logic [1:0]          state_t;
  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [ADDR_W:0]     count_t;
  typedef logic [DATA_W-1:0]   word_t;
  typedef logic [LINE_W-1:0]   line_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FILL  = 2'd1;
  localparam state_t ST_WRITE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam count_t COUNT_ONE = count_t'(1);
  localparam addr_t  ADDR_ONE  = addr_t'(1);

endpackage

// File: rtl/bram_line_writer_if.sv
// Word stream in, memory port A out. The engine sits on the slave side;
// the word producer / memory model sits on the master side.
interface bram_line_writer_if;
  import bram_line_writer_pkg::*;

  logic   in_valid;
  word_t  in_data;
  logic   in_last;
  logic   in_ready;
  logic   ena;
  logic   wea;
  addr_t  addra;
  line_t  dina;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, ena, wea, addra, dina
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, ena, wea, addra, dina
  );

endinterface

// File: rtl/bram_line_writer_line_packer_lanes.sv
// Lane buffer for one memory line: words land in successive lanes, lane 0 lowest.
// line_d is the buffer as it will be after this cycle, so the line can be registered on the final load.
module bram_line_writer_line_packer_lanes
  import bram_line_writer_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   load,
  input  logic   clear,
  input  word_t  din,
  input  logic   din_last,
  output logic   full,
  output logic   last,
  output line_t  line_d
);

  logic [LANES-1:0][DATA_W-1:0] lane_q, lane_d;
  logic [LANE_IDX_W-1:0]        idx_q, idx_d;
  logic                         last_q, last_d;

  always_comb begin
    lane_d = lane_q;
    idx_d  = idx_q;
    last_d = last_q;
    if (clear) begin
      lane_d = '0;
      idx_d  = '0;
      last_d = 1'b0;
    end else if (load) begin
      lane_d[idx_q] = din;
      idx_d         = idx_q + LANE_IDX_W'(1);
      last_d        = last_q | din_last;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lane_q <= '0;
      idx_q  <= '0;
      last_q <= 1'b0;
    end else begin
      lane_q <= lane_d;
      idx_q  <= idx_d;
      last_q <= last_d;
    end
  end

  assign full   = (idx_q == LANE_IDX_W'(LANES - 1));
  assign last   = last_q;
  assign line_d = lane_d;

endmodule

// File: rtl/bram_line_writer.sv
// Port-A fill engine: packs the word stream into lines and writes them to
// consecutive addresses from a latched base, then pulses done.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; stream not accepted
// ST_FILL  | accepting words into the lane buffer
// ST_WRITE | one-cycle port-A write of the packed line
// ST_DONE  | one-cycle done pulse, then back to idle
module bram_line_writer
  import bram_line_writer_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  addr_t               base_addr,
  input  count_t              line_count,
  bram_line_writer_if.slave   bus,
  output logic                busy,
  output logic                done,
  output count_t              lines_written
);

  state_t state_q, state_d;
  addr_t  cur_addr_q, cur_addr_d;
  count_t target_q, target_d;
  count_t lines_q, lines_d;
  logic   ena_q, ena_d;
  addr_t  addra_q, addra_d;
  line_t  dina_q, dina_d;

  logic   pk_load;
  logic   pk_clear;
  logic   pk_full;
  logic   pk_last;
  line_t  pk_line_d;
  count_t lines_inc;

  assign pk_load   = (state_q == ST_FILL) && bus.in_valid;
  assign pk_clear  = ((state_q == ST_IDLE) && start) || (state_q == ST_WRITE);
  assign lines_inc = lines_q + COUNT_ONE;

  bram_line_writer_line_packer_lanes u_line_packer_lanes (
    .clock    (clock),
    .reset    (reset),
    .load     (pk_load),
    .clear    (pk_clear),
    .din      (bus.in_data),
    .din_last (bus.in_last),
    .full     (pk_full),
    .last     (pk_last),
    .line_d   (pk_line_d)
  );

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    target_d   = target_q;
    lines_d    = lines_q;
    ena_d      = 1'b0;
    addra_d    = addra_q;
    dina_d     = dina_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_addr_d = base_addr;
          target_d   = line_count;
          lines_d    = '0;
          state_d    = (line_count == '0) ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        // Register the port-A beat on the word that completes the line.
        if (pk_load && (pk_full || bus.in_last)) begin
          ena_d   = 1'b1;
          addra_d = cur_addr_q;
          dina_d  = pk_line_d;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        cur_addr_d = cur_addr_q + ADDR_ONE;
        lines_d    = lines_inc;
        state_d    = ((lines_inc == target_q) || pk_last) ? ST_DONE : ST_FILL;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      target_q   <= '0;
      lines_q    <= '0;
      ena_q      <= 1'b0;
      addra_q    <= '0;
      dina_q     <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      target_q   <= target_d;
      lines_q    <= lines_d;
      ena_q      <= ena_d;
      addra_q    <= addra_d;
      dina_q     <= dina_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_FILL);
  assign bus.ena       = ena_q;
  assign bus.wea       = ena_q;
  assign bus.addra     = addra_q;
  assign bus.dina      = dina_q;
  assign busy          = (state_q == ST_FILL) || (state_q == ST_WRITE);
  assign done          = (state_q == ST_DONE);
  assign lines_written = lines_q;

endmodule

// File: tb/tb_bram_line_writer.sv
// Self-checking bench for bram_line_writer: a table of fill jobs plus
// hand-written short-line, start-while-busy and mid-line reset sequences.
module tb_bram_line_writer;
  import bram_line_writer_pkg::*;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [9:0]   base_addr = '0;
  logic [10:0]  line_count = '0;
  logic         busy;
  logic         done;
  logic [10:0]  lines_written;

  bram_line_writer_if bus();

  bram_line_writer dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .line_count    (line_count),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .lines_written (lines_written)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [15:0]  words [0:63];

  // write monitor, cleared whenever job_id changes
  int           job_id = 0;
  int           mon_id = 0;
  int           cyc = 0;
  int           wr_n = 0;
  int           done_cnt = 0;
  int           rdy_viol = 0;
  int           we_viol = 0;
  logic [9:0]   wr_addr [0:15];
  logic [127:0] wr_data [0:15];
  int           wr_cyc  [0:15];

  initial begin
    forever begin
      @(negedge clock);
      if (mon_id != job_id) begin
        mon_id   = job_id;
        wr_n     = 0;
        done_cnt = 0;
        rdy_viol = 0;
        we_viol  = 0;
      end
      cyc++;
      if (bus.ena !== bus.wea) we_viol++;
      if (bus.ena === 1'b1) begin
        if (wr_n < 16) begin
          wr_addr[wr_n] = bus.addra;
          wr_data[wr_n] = bus.dina;
          wr_cyc[wr_n]  = cyc;
        end
        wr_n++;
        if (bus.in_ready !== 1'b0) rdy_viol++;
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  function automatic logic [127:0] model_line(input int w, input int nacc);
    logic [127:0] l;
    l = '0;
    for (int k = 0; k < 8; k++)
      if (8 * w + k < nacc) l[16*k +: 16] = words[8*w + k];
    return l;
  endfunction

  task automatic send_words(input int off, input int n, input int last_at,
                            input bit gaps, output int acc);
    int  i;
    int  budget;
    bit  vld;
    bit  tog;
    bit  took;
    i = 0; acc = 0; tog = 1'b1;
    budget = n * 3 + 40;
    for (int c = 0; c < budget && i < n; c++) begin
      vld = gaps ? tog : 1'b1;
      tog = ~tog;
      bus.in_valid = vld;
      bus.in_data  = words[off + i];
      bus.in_last  = (off + i == last_at);
      @(negedge clock);
      took = vld && (bus.in_ready === 1'b1);
      @(posedge clock); #1;
      if (took) begin
        i++;
        acc++;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic pulse_start(input logic [9:0] b, input logic [10:0] c);
    base_addr  = b;
    line_count = c;
    start      = 1'b1;
    @(posedge clock); #1;
    start      = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 60 && done_cnt == 0; k++) @(posedge clock);
    repeat (3) @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [9:0]  base;
    logic [10:0] count;
    int          n_words;
    int          last_at;
    bit          gaps;
    int          exp_acc;
    int          exp_writes;
    logic [10:0] exp_lines;
    logic [9:0]  exp_addr0;
    logic [9:0]  exp_addr_last;
    int          exp_spacing;
  } job_t;

  job_t jobs [0:6];
  int   acc;
  int   acc2;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;

    jobs[0] = '{10'd0,    11'd2, 16, -1, 1'b0, 16, 2, 11'd2, 10'd0,    10'd1,    9};
    jobs[1] = '{10'd1023, 11'd2, 16, -1, 1'b0, 16, 2, 11'd2, 10'd1023, 10'd0,    9};
    jobs[2] = '{10'd5,    11'd1,  8, -1, 1'b1,  8, 1, 11'd1, 10'd5,    10'd5,    0};
    jobs[3] = '{10'd100,  11'd4, 16, 15, 1'b0, 16, 2, 11'd2, 10'd100,  10'd101,  9};
    jobs[4] = '{10'd200,  11'd2, 24, -1, 1'b0, 16, 2, 11'd2, 10'd200,  10'd201,  9};
    jobs[5] = '{10'd300,  11'd3, 11, 10, 1'b0, 11, 2, 11'd2, 10'd300,  10'd301,  0};
    jobs[6] = '{10'd7,    11'd0,  0, -1, 1'b0,  0, 0, 11'd0, 10'd0,    10'd0,    0};

    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_ena", bus.ena, 0);
    check("rst_wea", bus.wea, 0);
    check("rst_addra", bus.addra, 0);
    check("rst_dina", bus.dina, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_lines_written", lines_written, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int j = 0; j < 7; j++) begin
      for (int i = 0; i < 64; i++) words[i] = 16'(j * 4096 + i);
      job_id++;
      @(posedge clock); #1;
      pulse_start(jobs[j].base, jobs[j].count);
      send_words(0, jobs[j].n_words, jobs[j].last_at, jobs[j].gaps, acc);
      wait_done();
      check("job_accepted", acc, jobs[j].exp_acc);
      check("job_writes", wr_n, jobs[j].exp_writes);
      check("job_lines_written", lines_written, jobs[j].exp_lines);
      check("job_done_pulses", done_cnt, 1);
      check("job_busy_after", busy, 0);
      check("job_ready_in_write", rdy_viol, 0);
      check("job_ena_wea", we_viol, 0);
      if (wr_n > 0 && wr_n <= 16) begin
        check("job_addr_first", wr_addr[0], jobs[j].exp_addr0);
        check("job_addr_last", wr_addr[wr_n-1], jobs[j].exp_addr_last);
        for (int w = 0; w < wr_n; w++)
          check("job_line_data", wr_data[w], model_line(w, jobs[j].exp_acc));
      end
      if (jobs[j].exp_spacing != 0 && wr_n >= 2)
        check("job_write_spacing", wr_cyc[1] - wr_cyc[0], jobs[j].exp_spacing);
    end

    // short line ended by in_last
    words[0] = 16'hAAAA; words[1] = 16'hBBBB; words[2] = 16'hCCCC;
    job_id++;
    @(posedge clock); #1;
    pulse_start(10'd50, 11'd4);
    send_words(0, 3, 2, 1'b0, acc);
    wait_done();
    check("short_writes", wr_n, 1);
    check("short_addr", wr_addr[0], 10'd50);
    check("short_data", wr_data[0], 128'hCCCC_BBBB_AAAA);
    check("short_lines_written", lines_written, 1);
    check("short_done_pulses", done_cnt, 1);

    // start while busy must not disturb the running job
    for (int i = 0; i < 64; i++) words[i] = 16'(16'h5000 + i);
    job_id++;
    @(posedge clock); #1;
    pulse_start(10'd400, 11'd2);
    send_words(0, 4, -1, 1'b0, acc);
    pulse_start(10'd600, 11'd1);
    send_words(4, 12, -1, 1'b0, acc2);
    wait_done();
    check("busy_start_writes", wr_n, 2);
    check("busy_start_addr0", wr_addr[0], 10'd400);
    check("busy_start_addr1", wr_addr[1], 10'd401);
    check("busy_start_lines", lines_written, 2);
    check("busy_start_data0", wr_data[0], model_line(0, 16));
    check("busy_start_data1", wr_data[1], model_line(1, 16));

    // reset after 5 words of a line
    for (int i = 0; i < 64; i++) words[i] = 16'(16'h7700 + i);
    job_id++;
    @(posedge clock); #1;
    pulse_start(10'd10, 11'd1);
    send_words(0, 5, -1, 1'b0, acc);
    reset = 1'b1;
    @(posedge clock); #1;
    check("mid_rst_in_ready", bus.in_ready, 0);
    check("mid_rst_ena", bus.ena, 0);
    check("mid_rst_wea", bus.wea, 0);
    check("mid_rst_addra", bus.addra, 0);
    check("mid_rst_dina", bus.dina, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_lines_written", lines_written, 0);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("mid_rst_no_write", wr_n, 0);

    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
    job_id++;
    @(posedge clock); #1;
    pulse_start(10'd20, 11'd2);
    send_words(0, 3, 2, 1'b0, acc);
    wait_done();
    check("post_rst_writes", wr_n, 1);
    check("post_rst_addr", wr_addr[0], 10'd20);
    check("post_rst_data", wr_data[0], 128'h3333_2222_1111);
    check("post_rst_lines", lines_written, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_line_writer.md
Name: bram_line_writer

Overview:
- Port-A fill engine for the 128-bit x 1024-line block memory, whose port B is read sequentially by the compute side.
- Accepts a stream of 16-bit words over a valid/ready handshake.
- Packs eight words per line, lane 0 in bits [15:0] and lane 7 in bits [127:112].
- Writes each completed line to consecutive addresses starting at a programmed base, then signals done.

Parameters:
- DATA_W, 16, width of one input word / lane
- LANES, 8, words per memory line (line width = DATA_W*LANES = 128)
- ADDR_W, 10, memory address width (1024 lines)

Ports:
- clock  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a fill job (ignored unless idle)
- base_addr  input  ADDR_W  first line address, latched on start
- line_count  input  ADDR_W+1  number of lines to write (1..1024), latched on start
- in_valid  input  1  input word valid
- in_data  input  DATA_W  input word
- in_last  input  1  marks final word of job; qualified by in_valid
- in_ready  output  1  block can accept a word this cycle
- ena  output  1  port-A enable
- wea  output  1  port-A write enable
- addra  output  ADDR_W  port-A address
- dina  output  DATA_W*LANES  port-A write data
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle completion pulse
- lines_written  output  ADDR_W+1  lines written in current/last job

Behaviour:
- Reset values: in_ready=0, ena=0, wea=0, addra=0, dina=0, busy=0, done=0, lines_written=0. Lane buffer cleared, state IDLE.
- IDLE
  - start=1 latches base_addr into cur_addr and line_count into target, clears lines_written and the lane buffer.
  - If line_count==0, go to DONE; otherwise go to FILL.
- FILL
  - in_ready=1.
  - A word is accepted when in_valid & in_ready; it is stored in lane lane_idx, and lane_idx increments.
  - When the accepted word is in lane LANES-1, or in_last=1, go to WRITE.
- WRITE (exactly one cycle)
  - in_ready=0; ena=wea=1, addra=cur_addr, dina=packed buffer.
  - Lanes not filled on a short (in_last) line are driven 0.
  - Next cycle: cur_addr <= cur_addr+1 modulo 2^ADDR_W (1023 wraps to 0), lines_written increments, lane buffer and lane_idx clear.
  - If lines_written+1==target or the line ended by in_last, go to DONE; else go to FILL.
- DONE: done=1 for one cycle, busy drops in the same cycle; return to IDLE.
- Outside WRITE, ena=wea=0. addra/dina hold the last written values (don't-care to memory).
- Throughput: one line per LANES+1 cycles under continuous in_valid (8 beats + 1 write bubble).
- in_last
  - in_last on lane 7 is a normal full line that also ends the job.
  - in_last before target is reached ends the job early; lines_written reports the actual count.
  - in_last while idle is ignored.
- Target reached without in_last: words presented after done are not accepted (in_ready=0 in IDLE).
- start while busy is ignored; latched parameters are unchanged.
- Reset mid-job, including during WRITE: wea deasserts the same edge, and no partial line is written afterwards.

Decomposition:
- Shared package holds:
  - DATA_W, LANES, ADDR_W, LINE_W=DATA_W*LANES
  - state enum {IDLE, FILL, WRITE, DONE}
- One natural sub-module: line_packer_lanes.
  - Holds the lane buffer and lane_idx.
  - Has load, clear and full/last flags.
- The top keeps the FSM, the address counter and the line counter.

Test Plan:
- Reset, start base_addr=0, line_count=2, words 0x0000..0x000F with in_valid held high:
  - Two write cycles, at addra 0 then 1.
  - Line 0 has dina[15:0]=0x0000 and dina[127:112]=0x0007.
  - Writes occur 9 cycles apart; done pulses once; lines_written=2.
- Wrap: base_addr=1023, line_count=2 -> writes at addra 1023 then 0.
- Short line: line_count=4, send 3 words 0xAAAA,0xBBBB,0xCCCC with in_last on the third:
  - One write at base with dina[47:0]=0xCCCC_BBBB_AAAA and upper 80 bits zero.
  - done asserts; lines_written=1.
- Backpressure/gaps: toggle in_valid every other cycle for line_count=1:
  - Exactly one write after the 8th accepted word, with the correct packing.
  - in_ready=0 during the write cycle.
- start pulsed mid-job with a different base_addr -> ignored; addresses follow the original base.
- Assert reset after 5 words of a line -> no write occurs, all outputs at reset values.
  - A subsequent job writes a line with no stale lanes.
